// File: rtl/piradip_trigger_pkg.sv
// Shared state type and signed threshold-crossing compare for the AXI-Stream level trigger.
package piradip_trigger_pkg;

    typedef enum logic [1:0] {
        TRIG_IDLE,
        TRIG_ARMED,
        TRIG_HOLDOFF
    } trig_state_t;

    // Samples are sign-extended to this width before comparing; supports SAMPLE_WIDTH up to 64.
    localparam int CMP_WIDTH = 64;

    function automatic logic is_crossing(
        input logic signed [CMP_WIDTH-1:0] cur,
        input logic signed [CMP_WIDTH-1:0] prev,
        input logic signed [CMP_WIDTH-1:0] thr,
        input logic                        rising
    );
        if (rising) begin
            return (prev < thr) && (cur >= thr);
        end
        return (prev >= thr) && (cur < thr);
    endfunction

endpackage

// File: rtl/piradip_lane_crossing_detect.sv
// Combinational per-lane crossing detector with a lowest-lane-wins priority encoder.
module piradip_lane_crossing_detect
    import piradip_trigger_pkg::*;
#(
    parameter  int SAMPLE_WIDTH     = 16,
    parameter  int SAMPLES_PER_BEAT = 4,
    localparam int DATA_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_BEAT,
    localparam int LANE_WIDTH       = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1
) (
    input  logic [DATA_WIDTH-1:0]   beat_i,
    input  logic [SAMPLE_WIDTH-1:0] prev_sample_i,
    input  logic                    prev_valid_i,
    input  logic [SAMPLE_WIDTH-1:0] threshold_i,
    input  logic                    rising_i,
    output logic                    hit_o,
    output logic [LANE_WIDTH-1:0]   first_lane_o
);

    logic signed [CMP_WIDTH-1:0] thr_ext;
    // Index 0 holds the previous beat's last sample; index i+1 holds lane i.
    logic signed [CMP_WIDTH-1:0] sample_ext [SAMPLES_PER_BEAT+1];
    logic [SAMPLES_PER_BEAT-1:0] lane_hit;

    assign thr_ext       = CMP_WIDTH'($signed(threshold_i));
    assign sample_ext[0] = CMP_WIDTH'($signed(prev_sample_i));

    for (genvar g = 0; g < SAMPLES_PER_BEAT; g++) begin : g_lane
        assign sample_ext[g+1] = CMP_WIDTH'($signed(beat_i[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]));
        assign lane_hit[g]     = ((g != 0) || prev_valid_i)
                               && is_crossing(sample_ext[g+1], sample_ext[g], thr_ext, rising_i);
    end

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit_o        = |lane_hit;
        first_lane_o = '0;
        for (int i = SAMPLES_PER_BEAT - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                first_lane_o = LANE_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/piradip_axis_level_trigger.sv
// Single-register AXI-Stream pass-through that scans accepted beats for a threshold crossing
// and emits a one-cycle trigger aligned with the load of the crossing beat.
module piradip_axis_level_trigger
    import piradip_trigger_pkg::*;
#(
    parameter  int SAMPLE_WIDTH     = 16,
    parameter  int SAMPLES_PER_BEAT = 4,
    parameter  int HOLDOFF_WIDTH    = 16,
    localparam int DATA_WIDTH       = SAMPLE_WIDTH * SAMPLES_PER_BEAT,
    localparam int LANE_WIDTH       = (SAMPLES_PER_BEAT > 1) ? $clog2(SAMPLES_PER_BEAT) : 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     rising,
    input  logic                     one_shot,
    input  logic [SAMPLE_WIDTH-1:0]  threshold,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff,
    output logic                     trigger,
    output logic [LANE_WIDTH-1:0]    trigger_lane,
    output logic                     armed,
    output logic [31:0]              trigger_count
);

    logic [DATA_WIDTH-1:0]    m_tdata_q;
    logic                     m_tvalid_q;
    logic [SAMPLE_WIDTH-1:0]  prev_sample_q;
    logic                     prev_valid_q;
    trig_state_t              state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic                     trigger_q;
    logic [LANE_WIDTH-1:0]    trigger_lane_q;
    logic [31:0]              trigger_count_q;

    logic                     accept;
    logic                     hit;
    logic [LANE_WIDTH-1:0]    hit_lane;
    logic                     fire;

    assign s_tready = ~m_tvalid_q | m_tready;
    assign accept   = s_tvalid & s_tready;

    piradip_lane_crossing_detect #(
        .SAMPLE_WIDTH     (SAMPLE_WIDTH),
        .SAMPLES_PER_BEAT (SAMPLES_PER_BEAT)
    ) u_detect (
        .beat_i        (s_tdata),
        .prev_sample_i (prev_sample_q),
        .prev_valid_i  (prev_valid_q),
        .threshold_i   (threshold),
        .rising_i      (rising),
        .hit_o         (hit),
        .first_lane_o  (hit_lane)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            m_tdata_q     <= s_tdata;
            m_tvalid_q    <= 1'b1;
            prev_sample_q <= s_tdata[DATA_WIDTH-1 -: SAMPLE_WIDTH];
            prev_valid_q  <= 1'b1;
        end else if (m_tready) begin
            m_tvalid_q    <= 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        holdoff_cnt_d = holdoff_cnt_q;
        fire          = 1'b0;
        case (state_q)
            TRIG_IDLE: begin
                if (arm) begin
                    state_d = TRIG_ARMED;
                end
            end
            TRIG_ARMED: begin
                if (accept && hit) begin
                    fire = 1'b1;
                    if (one_shot) begin
                        state_d = TRIG_IDLE;
                    end else if (holdoff != '0) begin
                        state_d       = TRIG_HOLDOFF;
                        holdoff_cnt_d = holdoff;
                    end
                end
            end
            TRIG_HOLDOFF: begin
                // The beat that drains the counter re-arms but is itself never eligible.
                if (accept) begin
                    holdoff_cnt_d = holdoff_cnt_q - 1'b1;
                    if (holdoff_cnt_q == HOLDOFF_WIDTH'(1)) begin
                        state_d = TRIG_ARMED;
                    end
                end
            end
            default: state_d = TRIG_IDLE;
        endcase
        if (disarm) begin
            state_d = TRIG_IDLE;
            fire    = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= TRIG_IDLE;
            holdoff_cnt_q   <= '0;
            trigger_q       <= 1'b0;
            trigger_lane_q  <= '0;
            trigger_count_q <= '0;
        end else begin
            state_q       <= state_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            trigger_q     <= fire;
            if (fire) begin
                trigger_lane_q  <= hit_lane;
                trigger_count_q <= trigger_count_q + 32'd1;
            end
        end
    end

    assign m_tdata       = m_tdata_q;
    assign m_tvalid      = m_tvalid_q;
    assign trigger       = trigger_q;
    assign trigger_lane  = trigger_lane_q;
    assign armed         = (state_q == TRIG_ARMED);
    assign trigger_count = trigger_count_q;

endmodule

// File: tb/tb_piradip_axis_level_trigger.sv
// Directed-vector bench for piradip_axis_level_trigger: table of per-cycle vectors plus
// hand-written backpressure, mid-stream reset, throughput and random pass-through sequences.
module tb_piradip_axis_level_trigger;

    localparam int SW  = 16;
    localparam int SPB = 4;
    localparam int DW  = SW * SPB;
    localparam int LW  = 2;
    localparam int HW  = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          arm;
    logic          disarm;
    logic          rising;
    logic          one_shot;
    logic [SW-1:0] threshold;
    logic [HW-1:0] holdoff;
    logic          trigger;
    logic [LW-1:0] trigger_lane;
    logic          armed;
    logic [31:0]   trigger_count;

    always #5 aclk = ~aclk;

    piradip_axis_level_trigger #(
        .SAMPLE_WIDTH     (SW),
        .SAMPLES_PER_BEAT (SPB),
        .HOLDOFF_WIDTH    (HW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .arm           (arm),
        .disarm        (disarm),
        .rising        (rising),
        .one_shot      (one_shot),
        .threshold     (threshold),
        .holdoff       (holdoff),
        .trigger       (trigger),
        .trigger_lane  (trigger_lane),
        .armed         (armed),
        .trigger_count (trigger_count)
    );

    typedef struct {
        logic          rising;
        logic          one_shot;
        int            thr;
        int            hold;
        logic          arm;
        logic          disarm;
        logic          vld;
        logic [DW-1:0] data;
        logic          exp_trig;
        logic [LW-1:0] exp_lane;
        logic          exp_armed;
        int            exp_count;
    } vec_t;

    vec_t          vecs[$];
    int            n_vec = 0;
    int            n_mis = 0;
    logic [DW-1:0] bp_beat;
    logic [DW-1:0] dat;
    logic [DW-1:0] exp_mdata;
    logic          exp_mvalid;
    logic          exp_rdy;
    logic          r_vld;
    logic          r_rdy;
    int            beats;
    int            cycles;

    function automatic logic [DW-1:0] beat(input int l3, input int l2, input int l1, input int l0);
        return {SW'(l3), SW'(l2), SW'(l1), SW'(l0)};
    endfunction

    function automatic vec_t mk(input logic r, input logic os, input int t, input int h,
                                input logic a, input logic d, input logic v, input logic [DW-1:0] dt,
                                input logic et, input int el, input logic ea, input int ec);
        vec_t x;
        x.rising    = r;
        x.one_shot  = os;
        x.thr       = t;
        x.hold      = h;
        x.arm       = a;
        x.disarm    = d;
        x.vld       = v;
        x.data      = dt;
        x.exp_trig  = et;
        x.exp_lane  = LW'(el);
        x.exp_armed = ea;
        x.exp_count = ec;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // NOTE: inputs change on the falling edge with blocking writes so they are settled at posedge.
    task automatic drive(input logic vld, input logic [DW-1:0] data, input logic rdy,
                         input logic a, input logic d);
        @(negedge aclk);
        s_tvalid = vld;
        s_tdata  = data;
        m_tready = rdy;
        arm      = a;
        disarm   = d;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn   = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        m_tready  = 1'b1;
        arm       = 1'b0;
        disarm    = 1'b0;
        rising    = 1'b1;
        one_shot  = 1'b1;
        threshold = '0;
        holdoff   = '0;

        repeat (2) @(posedge aclk);
        #1;
        check("reset m_tvalid", 64'(m_tvalid), 64'(0));
        check("reset m_tdata", m_tdata, 64'(0));
        check("reset trigger", 64'(trigger), 64'(0));
        check("reset trigger_lane", 64'(trigger_lane), 64'(0));
        check("reset armed", 64'(armed), 64'(0));
        check("reset trigger_count", 64'(trigger_count), 64'(0));
        check("reset s_tready", 64'(s_tready), 64'(1));
        @(negedge aclk);
        aresetn = 1'b1;

        //                rise os thr hold arm dis vld data                  trig lane armed cnt
        // One-shot rising, first beat after reset: lane 0 blocked, lane 2 crosses.
        vecs.push_back(mk(1, 1, 100, 0, 1, 0, 0, '0,                    0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 1, beat(200, 150, 50, 0), 1, 2, 0, 1));
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 0, '0,                    0, 2, 0, 1));
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 1, beat(0, 0, 0, 0),      0, 2, 0, 1));
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 1, beat(500, 0, 0, 0),    0, 2, 0, 1));
        // Beat-boundary crossing; arm coincident with a crossing beat leaves that beat ineligible.
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, beat(-5, 20, -5, -5),    0, 2, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, beat(30, 20, 10, 10),    1, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, beat(-5, -5, -5, -5),    0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, '0,                      0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, '0,                      0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, '0,                      0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, beat(10, 10, 10, 10),    1, 0, 0, 3));
        // Continuous, holdoff 3, crossing in every beat: fires on beats 0, 4, 8.
        vecs.push_back(mk(1, 0, 0, 3, 1, 0, 0, '0,                      0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  1, 2, 0, 4));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 2, 0, 4));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 2, 0, 4));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 2, 1, 4));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  1, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  0, 0, 1, 5));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, beat(-10, 10, -10, 10),  1, 0, 0, 6));
        // arm+disarm together stays idle; holdoff 0 fires every beat; disarm beats a crossing.
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, '0,                      0, 0, 0, 6));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, '0,                      0, 0, 1, 6));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, beat(-10, 10, -10, 10),  1, 0, 1, 7));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, beat(-10, 10, -10, 10),  1, 0, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, beat(-10, 10, -10, 10),  1, 0, 1, 9));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, beat(-10, 10, -10, 10),  0, 0, 0, 9));
        // Falling crossing in the top lane, then a rising crossing landing exactly on threshold.
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, '0,                      0, 0, 1, 9));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, beat(-10, 10, 10, 10),   1, 3, 0, 10));
        vecs.push_back(mk(1, 1, 100, 0, 1, 0, 0, '0,                    0, 3, 1, 10));
        vecs.push_back(mk(1, 1, 100, 0, 0, 0, 1, beat(0, 0, 100, 99),   1, 1, 0, 11));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            rising    = v.rising;
            one_shot  = v.one_shot;
            threshold = SW'(v.thr);
            holdoff   = HW'(v.hold);
            drive(v.vld, v.data, 1'b1, v.arm, v.disarm);
            tick();
            check($sformatf("vec%0d trigger", i), 64'(trigger), 64'(v.exp_trig));
            check($sformatf("vec%0d trigger_lane", i), 64'(trigger_lane), 64'(v.exp_lane));
            check($sformatf("vec%0d armed", i), 64'(armed), 64'(v.exp_armed));
            check($sformatf("vec%0d trigger_count", i), 64'(trigger_count), 64'(v.exp_count));
            check($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(v.vld));
            if (v.vld) begin
                check($sformatf("vec%0d m_tdata", i), m_tdata, v.data);
            end
        end

        // Backpressure: crossing beat loaded while m_tready is low for five cycles.
        rising    = 1'b1;
        one_shot  = 1'b1;
        threshold = SW'(100);
        holdoff   = '0;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        check("bp armed", 64'(armed), 64'(1));
        check("bp drained", 64'(m_tvalid), 64'(0));
        bp_beat = beat(200, 150, 50, 0);
        drive(1'b1, bp_beat, 1'b0, 1'b0, 1'b0);
        #1;
        check("bp s_tready at load", 64'(s_tready), 64'(1));
        tick();
        check("bp trigger", 64'(trigger), 64'(1));
        check("bp trigger_lane", 64'(trigger_lane), 64'(2));
        check("bp trigger_count", 64'(trigger_count), 64'(12));
        check("bp m_tdata load", m_tdata, bp_beat);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, beat(999, i, 0, 0), 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("bp stall%0d s_tready", i), 64'(s_tready), 64'(0));
            tick();
            check($sformatf("bp stall%0d trigger", i), 64'(trigger), 64'(0));
            check($sformatf("bp stall%0d m_tvalid", i), 64'(m_tvalid), 64'(1));
            check($sformatf("bp stall%0d m_tdata", i), m_tdata, bp_beat);
            check($sformatf("bp stall%0d trigger_count", i), 64'(trigger_count), 64'(12));
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        check("bp release m_tvalid", 64'(m_tvalid), 64'(0));
        check("bp one-shot idle", 64'(armed), 64'(0));

        // Reset pulse mid-burst: outputs clear at once and lane 0 is blocked afterwards.
        threshold = '0;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        check("rst pre armed", 64'(armed), 64'(1));
        drive(1'b1, beat(-10, -10, -10, -10), 1'b1, 1'b0, 1'b0);
        tick();
        check("rst pre trigger", 64'(trigger), 64'(0));
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check("rst async m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst async m_tdata", m_tdata, 64'(0));
        check("rst async armed", 64'(armed), 64'(0));
        check("rst async trigger_count", 64'(trigger_count), 64'(0));
        check("rst async trigger_lane", 64'(trigger_lane), 64'(0));
        check("rst async trigger", 64'(trigger), 64'(0));
        @(negedge aclk);
        s_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        tick();
        check("rst rearm", 64'(armed), 64'(1));
        drive(1'b1, beat(20, 20, 20, 10), 1'b1, 1'b0, 1'b0);
        tick();
        check("rst lane0 blocked trigger", 64'(trigger), 64'(0));
        check("rst lane0 blocked armed", 64'(armed), 64'(1));
        drive(1'b1, beat(-10, -10, -10, -10), 1'b1, 1'b0, 1'b0);
        tick();
        check("rst mid trigger", 64'(trigger), 64'(0));
        drive(1'b1, beat(20, 20, 20, 10), 1'b1, 1'b0, 1'b0);
        tick();
        check("rst lane0 live trigger", 64'(trigger), 64'(1));
        check("rst lane0 live lane", 64'(trigger_lane), 64'(0));
        check("rst lane0 live count", 64'(trigger_count), 64'(1));

        // Full throughput while idle: one beat per cycle with m_tready held high.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            dat = {$urandom, $urandom};
            drive(1'b1, dat, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("thru%0d s_tready", i), 64'(s_tready), 64'(1));
            tick();
            check($sformatf("thru%0d m_tvalid", i), 64'(m_tvalid), 64'(1));
            check($sformatf("thru%0d m_tdata", i), m_tdata, dat);
        end

        // Random handshakes while idle: compare against a one-entry register-slice model.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        exp_mvalid = 1'b0;
        exp_mdata  = '0;
        beats      = 0;
        cycles     = 0;
        while (beats < 1000 && cycles < 8000) begin
            r_vld = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            dat   = {$urandom, $urandom};
            drive(r_vld, dat, r_rdy, 1'b0, 1'b0);
            #1;
            exp_rdy = !exp_mvalid || r_rdy;
            check("rand s_tready", 64'(s_tready), 64'(exp_rdy));
            tick();
            if (r_vld && exp_rdy) begin
                exp_mdata  = dat;
                exp_mvalid = 1'b1;
                beats++;
            end else if (r_rdy) begin
                exp_mvalid = 1'b0;
            end
            check("rand m_tvalid", 64'(m_tvalid), 64'(exp_mvalid));
            check("rand trigger idle", 64'(trigger), 64'(0));
            if (exp_mvalid) begin
                check("rand m_tdata", m_tdata, exp_mdata);
            end
            cycles++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
